// File: rtl/wb_master_bridge_if.sv
// rtl/wb_master_bridge_if.sv - core request and Wishbone bus signal bundle
//
// Purpose: groups the load/store-unit request/response signals and the
//          Wishbone classic initiator signals of wb_master_bridge.
// Modports:
//   master - bridge view: core request in, response out; Wishbone out, slave replies in.
//   slave  - environment view (core + Wishbone slave), directions mirrored.
// Signals:
//   req_i, we_i, size_i[1:0], signed_i, addr_i[ADDR_W-1:0], wdata_i[31:0]  core request
//   ready_o, done_o, err_o, rdata_o[31:0]                                  core response
//   cyc_o, stb_o, we_o, sel_o[3:0], adr_o[ADDR_W-1:0], dat_o[31:0]         Wishbone request
//   dat_i[31:0], ack_i, err_i                                              Wishbone reply
interface wb_master_bridge_if #(
  parameter int ADDR_W = 32
);
  logic              req_i;
  logic              we_i;
  logic [1:0]        size_i;
  logic              signed_i;
  logic [ADDR_W-1:0] addr_i;
  logic [31:0]       wdata_i;
  logic              ready_o;
  logic              done_o;
  logic              err_o;
  logic [31:0]       rdata_o;
  logic              cyc_o;
  logic              stb_o;
  logic              we_o;
  logic [3:0]        sel_o;
  logic [ADDR_W-1:0] adr_o;
  logic [31:0]       dat_o;
  logic [31:0]       dat_i;
  logic              ack_i;
  logic              err_i;

  modport master (
    input  req_i, we_i, size_i, signed_i, addr_i, wdata_i,
    output ready_o, done_o, err_o, rdata_o,
    output cyc_o, stb_o, we_o, sel_o, adr_o, dat_o,
    input  dat_i, ack_i, err_i
  );

  modport slave (
    output req_i, we_i, size_i, signed_i, addr_i, wdata_i,
    input  ready_o, done_o, err_o, rdata_o,
    input  cyc_o, stb_o, we_o, sel_o, adr_o, dat_o,
    output dat_i, ack_i, err_i
  );
endinterface

// File: rtl/wb_master_bridge.sv
// rtl/wb_master_bridge.sv - Wishbone classic single-transfer initiator for the load/store unit
//
// Purpose: turns one core request (byte/half/word, signed/unsigned load or store)
//          into one Wishbone classic cycle, with byte selects, lane replication,
//          load extraction/extension, and error reporting (misaligned, illegal
//          size, slave error, timeout).
// Ports:
//   clk_i   in  clock, rising edge
//   rst_ni  in  asynchronous active-low reset
//   bus     wb_master_bridge_if.master (core request/response + Wishbone signals)
// Parameters:
//   TIMEOUT  max strobe cycles without ack/err before the cycle is aborted (>=2)
//   ADDR_W   address width
module wb_master_bridge #(
  parameter int TIMEOUT = 16,
  parameter int ADDR_W  = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  wb_master_bridge_if.master  bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;

  logic              r_we;
  logic              r_signed;
  logic              r_err;
  logic [1:0]        r_size;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rdata;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_legal;
  logic              w_tmo;
  logic [3:0]        w_sel;
  logic [31:0]       w_dat;
  logic [31:0]       w_load;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;

  // Legality is judged on the live request so a bad one skips the bus entirely.
  always_comb begin
    w_legal = 1'b0;
    case (bus.size_i)
      2'b00:   w_legal = 1'b1;
      2'b01:   w_legal = ~bus.addr_i[0];
      2'b10:   w_legal = (bus.addr_i[1:0] == 2'b00);
      default: w_legal = 1'b0;
    endcase
  end

  // Counter holds the number of completed strobe cycles, so hitting TIMEOUT-1
  // at an edge means stb_o has been high for exactly TIMEOUT cycles.
  assign w_tmo = (r_cnt == CNT_W'(TIMEOUT - 1));

  always_comb begin
    w_sel = 4'b1111;
    w_dat = r_wdata;
    case (r_size)
      2'b00: begin
        w_sel = 4'b0001 << r_addr[1:0];
        w_dat = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        w_sel = r_addr[1] ? 4'b1100 : 4'b0011;
        w_dat = {2{r_wdata[15:0]}};
      end
      default: begin
        w_sel = 4'b1111;
        w_dat = r_wdata;
      end
    endcase
  end

  always_comb begin
    w_byte = bus.dat_i[8*r_addr[1:0] +: 8];
    w_half = r_addr[1] ? bus.dat_i[31:16] : bus.dat_i[15:0];
    w_load = bus.dat_i;
    case (r_size)
      2'b00:   w_load = {{24{r_signed & w_byte[7]}}, w_byte};
      2'b01:   w_load = {{16{r_signed & w_half[15]}}, w_half};
      default: w_load = bus.dat_i;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    bus.ready_o = 1'b0;
    bus.done_o  = 1'b0;
    bus.err_o   = 1'b0;
    bus.cyc_o   = 1'b0;
    bus.stb_o   = 1'b0;
    bus.we_o    = 1'b0;
    bus.sel_o   = 4'b0000;
    bus.adr_o   = '0;
    bus.dat_o   = 32'h0;
    case (r_state)
      S_IDLE: begin
        bus.ready_o = 1'b1;
        if (bus.req_i) begin
          w_next = w_legal ? S_BUS : S_RESP;
        end
      end
      S_BUS: begin
        bus.cyc_o = 1'b1;
        bus.stb_o = 1'b1;
        bus.we_o  = r_we;
        bus.sel_o = w_sel;
        bus.adr_o = {r_addr[ADDR_W-1:2], 2'b00};
        bus.dat_o = w_dat;
        if (bus.ack_i || bus.err_i || w_tmo) begin
          w_next = S_RESP;
        end
      end
      S_RESP: begin
        bus.done_o = 1'b1;
        bus.err_o  = r_err;
        w_next     = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_we     <= 1'b0;
      r_signed <= 1'b0;
      r_err    <= 1'b0;
      r_size   <= 2'b00;
      r_addr   <= '0;
      r_wdata  <= 32'h0;
      r_rdata  <= 32'h0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (bus.req_i) begin
            r_we     <= bus.we_i;
            r_signed <= bus.signed_i;
            r_size   <= bus.size_i;
            r_addr   <= bus.addr_i;
            r_wdata  <= bus.wdata_i;
            r_err    <= ~w_legal;
          end
        end
        S_BUS: begin
          r_cnt <= r_cnt + CNT_W'(1);
          // Slave error takes priority over a simultaneous ack and blocks capture.
          if (bus.err_i) begin
            r_err <= 1'b1;
          end else if (bus.ack_i) begin
            r_err <= 1'b0;
            if (!r_we) begin
              r_rdata <= w_load;
            end
          end else if (w_tmo) begin
            r_err <= 1'b1;
          end
        end
        default: begin
          r_cnt <= '0;
        end
      endcase
    end
  end

  assign bus.rdata_o = r_rdata;

endmodule

// File: tb/tb_wb_master_bridge.sv
// tb/tb_wb_master_bridge.sv - self-checking bench for wb_master_bridge
module tb_wb_master_bridge;

  localparam int TIMEOUT = 16;
  localparam int R_ACK   = 0;
  localparam int R_ERR   = 1;
  localparam int R_BOTH  = 2;
  localparam int R_NEVER = 3;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [31:0] m_rdata;

  wb_master_bridge_if #(.ADDR_W(32)) bus ();

  wb_master_bridge #(.TIMEOUT(TIMEOUT), .ADDR_W(32)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          rsp;
    int          delay;
    logic [31:0] sdata;
    int          stb;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: derives the bus view and result purely from the request rules.
  task automatic model(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input int rsp, input int delay, input logic [31:0] sdata,
                       output int stb, output logic [3:0] sel, output logic [31:0] dat,
                       output logic err, output logic [31:0] rdata);
    int nbytes;
    int ofs;
    bit legal;
    bit tmo;
    logic [31:0] v;
    ofs    = int'(addr % 4);
    nbytes = (size == 2'd3) ? 0 : (1 << size);
    legal  = (nbytes != 0) && (ofs % nbytes == 0);
    tmo    = (rsp == R_NEVER) || (delay >= TIMEOUT);
    stb    = !legal ? 0 : (tmo ? TIMEOUT : delay + 1);
    sel    = 4'(((1 << nbytes) - 1) << ofs);
    if (nbytes == 1)      dat = (wdata & 32'hFF) * 32'h01010101;
    else if (nbytes == 2) dat = (wdata & 32'hFFFF) * 32'h00010001;
    else                  dat = wdata;
    err = !legal || tmo || (rsp != R_ACK);
    if (!err && !we) begin
      v = sdata >> (8 * ofs);
      if (nbytes == 1) begin
        v = v & 32'hFF;
        if (sgn && v[7]) v = v | 32'hFFFFFF00;
      end else if (nbytes == 2) begin
        v = v & 32'hFFFF;
        if (sgn && v[15]) v = v | 32'hFFFF0000;
      end
      m_rdata = v;
    end
    rdata = m_rdata;
  endtask

  task automatic xfer(input string tag, input logic we, input logic [1:0] size, input logic sgn,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input int rsp, input int delay, input logic [31:0] sdata, input bit noise,
                      input int exp_stb, input logic [3:0] exp_sel, input logic [31:0] exp_dat,
                      input logic exp_err, input logic [31:0] exp_rdata);
    int nstb;
    int first_stb;
    int done_cyc;
    int unstable;
    logic [3:0]  s_sel;
    logic [31:0] s_adr;
    logic [31:0] s_dat;
    logic        s_we;
    logic        got_err;
    logic [31:0] got_rdata;
    @(negedge clk);
    chk({tag, " ready"}, 32'(bus.ready_o), 32'd1);
    chk({tag, " done_idle"}, 32'(bus.done_o), 32'd0);
    bus.req_i    = 1'b1;
    bus.we_i     = we;
    bus.size_i   = size;
    bus.signed_i = sgn;
    bus.addr_i   = addr;
    bus.wdata_i  = wdata;
    bus.ack_i    = 1'($urandom);
    bus.err_i    = 1'($urandom);
    nstb = 0; first_stb = -1; done_cyc = -1; unstable = 0;
    s_sel = '0; s_adr = '0; s_dat = '0; s_we = 1'b0; got_err = 1'b0; got_rdata = '0;
    for (int cyc = 1; cyc <= 60 && done_cyc < 0; cyc++) begin
      @(negedge clk);
      if (bus.stb_o) begin
        nstb++;
        if (nstb == 1) begin
          first_stb = cyc;
          s_sel = bus.sel_o; s_adr = bus.adr_o; s_dat = bus.dat_o; s_we = bus.we_o;
        end else if (bus.sel_o !== s_sel || bus.adr_o !== s_adr ||
                     bus.dat_o !== s_dat || bus.we_o !== s_we) begin
          unstable++;
        end
      end
      if (bus.cyc_o !== bus.stb_o) unstable++;
      if (bus.done_o) begin
        done_cyc  = cyc;
        got_err   = bus.err_o;
        got_rdata = bus.rdata_o;
      end
      // A second request while busy must be ignored.
      bus.req_i   = (done_cyc < 0) ? noise : 1'b0;
      bus.addr_i  = $urandom;
      bus.size_i  = 2'($urandom);
      bus.we_i    = 1'($urandom);
      bus.wdata_i = $urandom;
      if (bus.stb_o && rsp != R_NEVER && nstb == delay + 1) begin
        bus.ack_i = (rsp == R_ACK) || (rsp == R_BOTH);
        bus.err_i = (rsp == R_ERR) || (rsp == R_BOTH);
        bus.dat_i = sdata;
      end else if (bus.stb_o) begin
        bus.ack_i = 1'b0;
        bus.err_i = 1'b0;
        bus.dat_i = $urandom;
      end else begin
        bus.ack_i = 1'($urandom);
        bus.err_i = 1'($urandom);
        bus.dat_i = $urandom;
      end
    end
    chk({tag, " stb_cycles"}, 32'(nstb), 32'(exp_stb));
    chk({tag, " done_cycle"}, 32'(done_cyc), 32'(exp_stb + 1));
    chk({tag, " err_o"}, 32'(got_err), 32'(exp_err));
    chk({tag, " rdata_o"}, got_rdata, exp_rdata);
    if (exp_stb > 0) begin
      chk({tag, " stb_start"}, 32'(first_stb), 32'd1);
      chk({tag, " sel_o"}, 32'(s_sel), 32'(exp_sel));
      chk({tag, " adr_o"}, s_adr, addr & 32'hFFFF_FFFC);
      chk({tag, " dat_o"}, s_dat, exp_dat);
      chk({tag, " we_o"}, 32'(s_we), 32'(we));
      chk({tag, " stable"}, 32'(unstable), 32'd0);
    end
  endtask

  initial begin
    int   r_stb;
    logic [3:0]  r_sel;
    logic [31:0] r_dat;
    logic        r_err;
    logic [31:0] r_rd;
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] sdata;
    int          rsp;
    int          delay;

    checks = 0;
    errors = 0;
    m_rdata = 32'h0;
    rst_n = 1'b0;
    bus.req_i = 1'b0; bus.we_i = 1'b0; bus.size_i = 2'b00; bus.signed_i = 1'b0;
    bus.addr_i = '0; bus.wdata_i = '0; bus.dat_i = '0; bus.ack_i = 1'b0; bus.err_i = 1'b0;

    tbl[0]  = '{1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, R_ACK,   1, 32'h0,        2,  4'hF, 32'hDEADBEEF, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 2'd0, 1'b1, 32'h13, 32'h0,        R_ACK,   1, 32'h80AABBCC, 2,  4'h8, 32'h0,        1'b0, 32'hFFFFFF80};
    tbl[2]  = '{1'b0, 2'd0, 1'b0, 32'h13, 32'h0,        R_ACK,   1, 32'h80AABBCC, 2,  4'h8, 32'h0,        1'b0, 32'h00000080};
    tbl[3]  = '{1'b1, 2'd1, 1'b0, 32'h22, 32'h1234,     R_ACK,   0, 32'h0,        1,  4'hC, 32'h12341234, 1'b0, 32'h00000080};
    tbl[4]  = '{1'b0, 2'd1, 1'b0, 32'h21, 32'h0,        R_ACK,   0, 32'h0,        0,  4'h0, 32'h0,        1'b1, 32'h00000080};
    tbl[5]  = '{1'b0, 2'd2, 1'b1, 32'h40, 32'h0,        R_ACK,   0, 32'h11223344, 1,  4'hF, 32'h0,        1'b0, 32'h11223344};
    tbl[6]  = '{1'b0, 2'd1, 1'b1, 32'h42, 32'h0,        R_ACK,   2, 32'h9ABC5678, 3,  4'hC, 32'h0,        1'b0, 32'hFFFF9ABC};
    tbl[7]  = '{1'b0, 2'd2, 1'b0, 32'h50, 32'h0,        R_NEVER, 0, 32'h0,        16, 4'hF, 32'h0,        1'b1, 32'hFFFF9ABC};
    tbl[8]  = '{1'b0, 2'd0, 1'b0, 32'h0,  32'h0,        R_BOTH,  0, 32'h55,       1,  4'h1, 32'h0,        1'b1, 32'hFFFF9ABC};
    tbl[9]  = '{1'b1, 2'd3, 1'b0, 32'h0,  32'h1,        R_ACK,   0, 32'h0,        0,  4'h0, 32'h0,        1'b1, 32'hFFFF9ABC};
    tbl[10] = '{1'b1, 2'd2, 1'b0, 32'h8,  32'h5,        R_ERR,   2, 32'h0,        3,  4'hF, 32'h5,        1'b1, 32'hFFFF9ABC};
    tbl[11] = '{1'b1, 2'd0, 1'b0, 32'h1,  32'hA5,       R_ACK,   0, 32'h0,        1,  4'h2, 32'hA5A5A5A5, 1'b0, 32'hFFFF9ABC};

    repeat (3) @(negedge clk);
    chk("rst ready_o", 32'(bus.ready_o), 32'd1);
    chk("rst done_o",  32'(bus.done_o),  32'd0);
    chk("rst err_o",   32'(bus.err_o),   32'd0);
    chk("rst cyc_o",   32'(bus.cyc_o),   32'd0);
    chk("rst stb_o",   32'(bus.stb_o),   32'd0);
    chk("rst we_o",    32'(bus.we_o),    32'd0);
    chk("rst sel_o",   32'(bus.sel_o),   32'd0);
    chk("rst adr_o",   bus.adr_o,        32'd0);
    chk("rst dat_o",   bus.dat_o,        32'd0);
    chk("rst rdata_o", bus.rdata_o,      32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      xfer($sformatf("vec%0d", i), tbl[i].we, tbl[i].size, tbl[i].sgn, tbl[i].addr,
           tbl[i].wdata, tbl[i].rsp, tbl[i].delay, tbl[i].sdata, 1'b1,
           tbl[i].stb, tbl[i].sel, tbl[i].dat, tbl[i].err, tbl[i].rdata);
    end
    m_rdata = 32'hFFFF9ABC;

    // Reset while the bus cycle is in flight.
    @(negedge clk);
    chk("midrst ready", 32'(bus.ready_o), 32'd1);
    bus.req_i = 1'b1; bus.we_i = 1'b0; bus.size_i = 2'd2; bus.signed_i = 1'b0;
    bus.addr_i = 32'h60; bus.ack_i = 1'b0; bus.err_i = 1'b0;
    @(negedge clk);
    bus.req_i = 1'b0;
    chk("midrst stb_before", 32'(bus.stb_o), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst cyc_o",   32'(bus.cyc_o),   32'd0);
    chk("midrst stb_o",   32'(bus.stb_o),   32'd0);
    chk("midrst ready_o", 32'(bus.ready_o), 32'd1);
    chk("midrst rdata_o", bus.rdata_o,      32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    m_rdata = 32'h0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("midrst no_done", 32'(bus.done_o),  32'd0);
      chk("midrst ready",   32'(bus.ready_o), 32'd1);
    end

    for (int i = 0; i < 150; i++) begin
      we    = 1'($urandom);
      size  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      sgn   = 1'($urandom);
      addr  = $urandom;
      wdata = $urandom;
      sdata = $urandom;
      rsp   = ($urandom_range(0, 9) == 0) ? R_NEVER : int'($urandom_range(0, 4) == 0 ? R_ERR :
              ($urandom_range(0, 4) == 0 ? R_BOTH : R_ACK));
      delay = int'($urandom_range(0, 5));
      model(we, size, sgn, addr, wdata, rsp, delay, sdata, r_stb, r_sel, r_dat, r_err, r_rd);
      xfer($sformatf("rnd%0d", i), we, size, sgn, addr, wdata, rsp, delay, sdata,
           1'($urandom), r_stb, r_sel, r_dat, r_err, r_rd);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
